// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates load/ALU results onto one register-file write port,
// with ALU anti-starvation. Optional pending-destination scoreboard under WB_SCOREBOARD_EN.
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  output logic [4:0]  a3,
  output logic [31:0] wd,
  output logic        wen,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q1,
  input  logic [4:0]  q2,
  output logic        busy1,
  output logic        busy2
);

  logic [1:0]  starve_q, starve_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;
  logic        wen_q, wen_d;
  logic        alu_pri;

  // ALU overrides the default load priority once it has waited three cycles.
  assign alu_pri = alu_valid && (starve_q == 2'd3);

  always_comb begin
    ld_ready  = 1'b0;
    alu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && (alu_pri || !ld_valid)) alu_ready = 1'b1;
      else if (ld_valid)                       ld_ready  = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || alu_ready) starve_d = 2'd0;
    else if (starve_q != 2'd3)   starve_d = starve_q + 2'd1;
  end

  always_comb begin
    a3_d  = a3_q;
    wd_d  = wd_q;
    wen_d = 1'b0;
    if (ld_ready) begin
      a3_d  = ld_rd;
      wd_d  = ld_data;
      wen_d = (ld_rd != 5'd0);
    end else if (alu_ready) begin
      a3_d  = alu_rd;
      wd_d  = alu_data;
      wen_d = (alu_rd != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 2'd0;
      a3_q     <= 5'd0;
      wd_q     <= 32'd0;
      wen_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
      wen_q    <= wen_d;
    end
  end

  // A result accepted just before reset must never reach the register file.
  assign a3  = a3_q;
  assign wd  = wd_q;
  assign wen = wen_q & ~rst;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending_q, pending_d;

  // Set is applied after clear so a newly issued producer wins over a retiring one.
  always_comb begin
    pending_d = pending_q;
    if (wen)                           pending_d[a3_q]   = 1'b0;
    if (iss_valid && iss_rd != 5'd0)   pending_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= 32'd0;
    else     pending_q <= pending_d;
  end

  assign busy1 = (q1 != 5'd0) && pending_q[q1];
  assign busy2 = (q2 != 5'd0) && pending_q[q2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, q1, q2};
  assign busy1 = 1'b0;
  assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scoreboard bench for writeback_unit: expected writes queued at drive time,
// compared one cycle later against a3/wd/wen.
module tb_writeback_unit;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, alu_valid, iss_valid;
  logic [4:0]  ld_rd, alu_rd, iss_rd, q1, q2;
  logic [31:0] ld_data, alu_data;
  logic        ld_ready, alu_ready, wen, busy1, busy2;
  logic [4:0]  a3;
  logic [31:0] wd;

  typedef struct {
    logic        wen;
    logic [4:0]  a3;
    logic [31:0] wd;
  } exp_t;

  exp_t        sbq[$];
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          checks = 0;
  int          failures = 0;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .a3(a3), .wd(wd), .wen(wen),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .q1(q1), .q2(q2),
    .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.wen = (rd != 5'd0);
    e.a3  = rd;
    e.wd  = d;
    m_a3  = rd;
    m_wd  = d;
    sbq.push_back(e);
  endtask

  // Check readies for the current inputs, queue the expected write, then compare it after the edge.
  task automatic cyc(input logic e_ld, input logic e_alu);
    exp_t e;
    #1;
    chk("ld_ready", ld_ready, e_ld);
    chk("alu_ready", alu_ready, e_alu);
    if (e_ld)       push(ld_rd, ld_data);
    else if (e_alu) push(alu_rd, alu_data);
    else begin
      e.wen = 1'b0; e.a3 = m_a3; e.wd = m_wd;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      chk("wen", wen, e.wen);
      chk("a3", a3, e.a3);
      chk("wd", wd, e.wd);
    end
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b1; alu_valid = 1'b1; iss_valid = 1'b1;
    ld_rd = 5'd4; ld_data = 32'h1111; alu_rd = 5'd6; alu_data = 32'h2222;
    iss_rd = 5'd2; q1 = 5'd2; q2 = 5'd0;
    m_a3 = 5'd0; m_wd = 32'd0;

    // reset: readies low while rst, outputs cleared
    #1;
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0; iss_valid = 1'b0;
    chk("rst_wen", wen, 1'b0);
    chk("rst_a3", a3, 5'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_busy1", busy1, 1'b0);

    // single load, then idle holds
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEADBEEF;
    cyc(1'b1, 1'b0);
    ld_valid = 1'b0;
    cyc(1'b0, 1'b0);

    // ALU write to x0: accepted, no enable, data still visible
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    cyc(1'b0, 1'b1);
    alu_valid = 1'b0;
    cyc(1'b0, 1'b0);

    // contention: L,L,L,A then counter restarts: L,L,L,A; ALU data changes while waiting
    ld_valid = 1'b1; alu_valid = 1'b1; alu_rd = 5'd12;
    for (int i = 0; i < 8; i++) begin
      ld_rd = 5'(i + 1); ld_data = 32'hA000_0000 + 32'(i); alu_data = 32'hB000_0000 + 32'(i);
      cyc((i % 4) != 3, (i % 4) == 3);
    end

    // dropping alu_valid clears the counter: L,L,(alu off) L, then L,L,L,A
    ld_rd = 5'd20; ld_data = 32'hC0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    alu_valid = 1'b0; ld_data = 32'hC1;
    cyc(1'b1, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hD0;
    for (int i = 0; i < 4; i++) begin
      ld_data = 32'hC2 + 32'(i);
      cyc(i != 3, i == 3);
    end
    ld_valid = 1'b0;
    alu_valid = 1'b0;
    cyc(1'b0, 1'b0);

    // scoreboard: issue x7, write x7 back, x9 reissued on its own retire edge
    iss_valid = 1'b1; iss_rd = 5'd7; q1 = 5'd7; q2 = 5'd0;
    cyc(1'b0, 1'b0);
    iss_valid = 1'b0;
    chk("busy1_set", busy1, SB);
    chk("busy2_q0", busy2, 1'b0);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    cyc(1'b1, 1'b0);
    ld_valid = 1'b0;
    chk("busy1_wen_cycle", busy1, SB);
    cyc(1'b0, 1'b0);
    chk("busy1_cleared", busy1, 1'b0);
    chk("busy2_q0_b", busy2, 1'b0);

    iss_valid = 1'b1; iss_rd = 5'd9; q1 = 5'd9;
    cyc(1'b0, 1'b0);
    iss_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    cyc(1'b1, 1'b0);
    ld_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
    cyc(1'b0, 1'b0);
    iss_valid = 1'b0;
    chk("busy1_set_wins", busy1, SB);
    cyc(1'b0, 1'b0);
    chk("busy1_still_set", busy1, SB);

    // reset right after an accepted load to x3 discards it
    iss_valid = 1'b1; iss_rd = 5'd3; q1 = 5'd3; q2 = 5'd9;
    @(posedge clk); #1;
    iss_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333;
    #1;
    chk("x3_ld_ready", ld_ready, 1'b1);
    @(posedge clk); #1;
    ld_valid = 1'b0; rst = 1'b1;
    #1;
    chk("x3_wen_in_rst", wen, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("x3_wen_after", wen, 1'b0);
    chk("x3_a3_after", a3, 5'd0);
    chk("x3_wd_after", wd, 32'd0);
    chk("x3_busy1", busy1, 1'b0);
    chk("x3_busy2", busy2, 1'b0);
    sbq.delete();
    m_a3 = 5'd0; m_wd = 32'd0;
    cyc(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: ld_valid in 1, ld_rd in 5, ld_data in 32, ld_ready out 1  (load-result source handshake).
REQ-004 SHALL have ports: alu_valid in 1, alu_rd in 5, alu_data in 32, alu_ready out 1  (ALU-result source handshake).
REQ-005 SHALL have ports: a3 out 5, wd out 32, wen out 1  (register-file write port: destination, data, enable).
REQ-006 SHALL have ports: iss_valid in 1, iss_rd in 5  (issue stage marks a destination pending).
REQ-007 SHALL have ports: q1 in 5, q2 in 5, busy1 out 1, busy2 out 1  (hazard query for the two source operands).
REQ-008 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-009 SHALL accept at most one source per cycle; a transfer occurs when valid and ready are both 1 on a rising edge.
REQ-010 SHALL drive ready combinationally; ready SHALL be 1 only for the granted source with valid=1, and 0 for both while rst=1.
REQ-011 Default grant SHALL favour load over ALU when both are valid.
REQ-012 SHALL keep a 2-bit starvation counter: +1 each cycle alu_valid=1 and alu_ready=0; cleared on ALU transfer or alu_valid=0; saturates at 3.
REQ-013 When counter==3 and alu_valid=1, ALU SHALL be granted over load; the counter then clears.
REQ-014 Accepted transfer SHALL appear on a3/wd one cycle later (latency 1), wen=1 for exactly that cycle.
REQ-015 Transfer with rd==0 SHALL be accepted (ready=1) but produce wen=0; a3/wd SHALL still update.
REQ-016 No transfer in a cycle SHALL give wen=0 next cycle; a3/wd hold their last values.
REQ-017 Output stage SHALL never stall; the write port sustains one write per cycle back-to-back.
REQ-018 Source data/rd SHALL be sampled only on the transfer edge; changes while valid=1 and ready=0 SHALL have no effect.
REQ-019 Scoreboard: 32-bit pending vector; bit iss_rd set on edge with iss_valid=1 and iss_rd!=0.
REQ-020 Pending bit a3 SHALL clear on the edge ending a cycle with wen=1 (same edge the register file writes).
REQ-021 Simultaneous set and clear of the same bit SHALL leave it set (newer producer wins).
REQ-022 busy1 = pending[q1], busy2 = pending[q2], combinational; q==0 SHALL always give busy=0; bit 0 never set.

Reset
REQ-023 On rst=1 at a rising edge: wen=0, a3=0, wd=0, pending=0, starvation counter=0.
REQ-024 Reset mid-operation SHALL discard any accepted-but-unwritten result: wen=0 the cycle after reset, no register write.
REQ-025 busy1/busy2 SHALL read 0 the cycle after reset; ready SHALL be 0 during any cycle with rst=1.

Configuration
REQ-026 Macro WB_SCOREBOARD_EN defined: scoreboard per REQ-019..022 present.
REQ-027 Macro WB_SCOREBOARD_EN undefined: no pending state; busy1=busy2=0 constantly; iss_valid/iss_rd/q1/q2 ignored; arbitration/write path unchanged.

Verification
REQ-028 ld_valid=1, ld_rd=5, ld_data=0xDEADBEEF one cycle -> ld_ready=1 that cycle; next cycle wen=1, a3=5, wd=0xDEADBEEF; following cycle wen=0.
REQ-029 ld_valid and alu_valid both held 1 for 5 cycles -> transfers L,L,L,A,L; ALU granted on 4th cycle; counter cleared after.
REQ-030 alu_valid=1, alu_rd=0, alu_data=0x1234 -> alu_ready=1; next cycle wen=0, a3=0, wd=0x1234.
REQ-031 (WB_SCOREBOARD_EN) iss_rd=7, q1=7 -> busy1=1 next cycle; ld write rd=7 -> busy1=1 during wen cycle, 0 the cycle after; q2=0 -> busy2=0 throughout.
REQ-032 (WB_SCOREBOARD_EN) iss_valid=1, iss_rd=9 on the same edge that ends a wen=1, a3=9 cycle -> pending[9] remains 1, busy1=1 with q1=9.
REQ-033 ld transfer rd=3 accepted, rst=1 the next cycle -> wen=0, a3=0, wd=0 after reset; no write of x3; all busy=0.
